// File: rtl/rf_pkg.sv
// Shared constants, types and helpers for the integer register file / scoreboard.
// Optional build macro used by this slice: REGFILE_BYPASS_EN.
package rf_pkg;

    localparam int XLEN   = 64;
    localparam int NREG   = 32;
    localparam int ADDR_W = 5;
    localparam int PEND_W = 2;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;
    typedef logic [PEND_W-1:0] pend_cnt_t;

    localparam pend_cnt_t PEND_MAX = {PEND_W{1'b1}};

    // True when both addresses match and refer to a real (non-x0) register.
    function automatic logic addr_hit(input reg_addr_t a, input reg_addr_t b);
        return (a == b) && (a != {ADDR_W{1'b0}});
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bundle for regfile_sb: master = pipeline side, slave = register file.
interface regfile_sb_if;
    import rf_pkg::*;

    reg_addr_t rd_addr1_i;
    xlen_t     rd_data1_o;
    reg_addr_t rd_addr2_i;
    xlen_t     rd_data2_o;
    logic      rs1_use_i;
    logic      rs2_use_i;
    logic      stall_o;
    logic      issue_valid_i;
    reg_addr_t issue_rd_i;
    logic      wb_en_i;
    reg_addr_t wb_addr_i;
    xlen_t     wb_data_i;
    logic      flush_i;
    logic      err_o;

    modport master (
        output rd_addr1_i, rd_addr2_i, rs1_use_i, rs2_use_i,
        output issue_valid_i, issue_rd_i, wb_en_i, wb_addr_i, wb_data_i, flush_i,
        input  rd_data1_o, rd_data2_o, stall_o, err_o
    );

    modport slave (
        input  rd_addr1_i, rd_addr2_i, rs1_use_i, rs2_use_i,
        input  issue_valid_i, issue_rd_i, wb_en_i, wb_addr_i, wb_data_i, flush_i,
        output rd_data1_o, rd_data2_o, stall_o, err_o
    );
endinterface

// File: rtl/rf_pend_cnt.sv
// Saturating pending-write counter for one register; ovf/unf flag a rejected step.
// With REGFILE_BYPASS_EN an extra one_o output reports "exactly one write outstanding".
module rf_pend_cnt
    import rf_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    input  logic clr_i,
`ifdef REGFILE_BYPASS_EN
    output logic one_o,
`endif
    output logic nonzero_o,
    output logic ovf_o,
    output logic unf_o
);

    pend_cnt_t cnt_q;
    pend_cnt_t cnt_d;

    // Next count: clear wins, a matched inc/dec pair cancels, otherwise step with saturation.
    always_comb begin
        cnt_d = cnt_q;
        ovf_o = 1'b0;
        unf_o = 1'b0;
        if (clr_i) begin
            cnt_d = {PEND_W{1'b0}};
        end else if (inc_i && dec_i) begin
            cnt_d = cnt_q;
        end else if (inc_i) begin
            if (cnt_q == PEND_MAX) begin
                ovf_o = 1'b1;
            end else begin
                cnt_d = cnt_q + PEND_W'(1);
            end
        end else if (dec_i) begin
            if (cnt_q == {PEND_W{1'b0}}) begin
                unf_o = 1'b1;
            end else begin
                cnt_d = cnt_q - PEND_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {PEND_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign nonzero_o = (cnt_q != {PEND_W{1'b0}});
`ifdef REGFILE_BYPASS_EN
    assign one_o     = (cnt_q == PEND_W'(1));
`endif

endmodule

// File: rtl/regfile_sb.sv
// Integer register file with per-register pending-write scoreboard for the in-order core.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module regfile_sb
    import rf_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    regfile_sb_if.slave  bus
);

    xlen_t regs_q [NREG];
    xlen_t regs_d [NREG];

    logic [NREG-1:1] inc_s;
    logic [NREG-1:1] dec_s;
    logic [NREG-1:1] ovf_s;
    logic [NREG-1:1] unf_s;
    logic [NREG-1:0] nz_s;
`ifdef REGFILE_BYPASS_EN
    logic [NREG-1:0] one_s;
`endif

    xlen_t rd_data1_s;
    xlen_t rd_data2_s;
    logic  pend1_s;
    logic  pend2_s;
    logic  fwd1_s;
    logic  fwd2_s;
    logic  stall_s;
    logic  err_d;
    logic  err_q;

    // Per-register issue/writeback strobes; x0 has no counter and is never decoded.
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_s[r] = bus.issue_valid_i && addr_hit(bus.issue_rd_i, ADDR_W'(r));
            dec_s[r] = bus.wb_en_i && addr_hit(bus.wb_addr_i, ADDR_W'(r));
        end
    end

    assign nz_s[0] = 1'b0;
`ifdef REGFILE_BYPASS_EN
    assign one_s[0] = 1'b0;
`endif

    for (genvar r = 1; r < NREG; r++) begin : g_cnt
        rf_pend_cnt u_cnt (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc_i     (inc_s[r]),
            .dec_i     (dec_s[r]),
            .clr_i     (bus.flush_i),
`ifdef REGFILE_BYPASS_EN
            .one_o     (one_s[r]),
`endif
            .nonzero_o (nz_s[r]),
            .ovf_o     (ovf_s[r]),
            .unf_o     (unf_s[r])
        );
    end

    // Architectural write; x0 is pinned to zero so reads never need a special case.
    always_comb begin
        regs_d = regs_q;
        if (bus.wb_en_i && (bus.wb_addr_i != {ADDR_W{1'b0}})) begin
            regs_d[bus.wb_addr_i] = bus.wb_data_i;
        end else begin
            regs_d[0] = {XLEN{1'b0}};
        end
    end

    // Register array storage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read ports plus hazard detection; forwarding only exists in the bypass build.
    always_comb begin
        rd_data1_s = regs_q[bus.rd_addr1_i];
        rd_data2_s = regs_q[bus.rd_addr2_i];
        pend1_s    = nz_s[bus.rd_addr1_i] && (bus.rd_addr1_i != {ADDR_W{1'b0}});
        pend2_s    = nz_s[bus.rd_addr2_i] && (bus.rd_addr2_i != {ADDR_W{1'b0}});
`ifdef REGFILE_BYPASS_EN
        if (bus.wb_en_i && addr_hit(bus.wb_addr_i, bus.rd_addr1_i)) begin
            rd_data1_s = bus.wb_data_i;
        end else begin
            rd_data1_s = regs_q[bus.rd_addr1_i];
        end
        if (bus.wb_en_i && addr_hit(bus.wb_addr_i, bus.rd_addr2_i)) begin
            rd_data2_s = bus.wb_data_i;
        end else begin
            rd_data2_s = regs_q[bus.rd_addr2_i];
        end
        fwd1_s = bus.wb_en_i && addr_hit(bus.wb_addr_i, bus.rd_addr1_i) && one_s[bus.rd_addr1_i];
        fwd2_s = bus.wb_en_i && addr_hit(bus.wb_addr_i, bus.rd_addr2_i) && one_s[bus.rd_addr2_i];
`else
        fwd1_s = 1'b0;
        fwd2_s = 1'b0;
`endif
        stall_s = (bus.rs1_use_i && pend1_s && !fwd1_s) ||
                  (bus.rs2_use_i && pend2_s && !fwd2_s);
    end

    // Any rejected counter step this cycle becomes a one-cycle error pulse next cycle.
    always_comb begin
        err_d = (|ovf_s) || (|unf_s);
    end

    // Error pulse register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.rd_data1_o = rd_data1_s;
    assign bus.rd_data2_o = rd_data2_s;
    assign bus.stall_o    = stall_s;
    assign bus.err_o      = err_q;

endmodule
